// File: rtl/fib_sequencer.sv
// Purpose: issues the Fibonacci program to the Decoder, then dumps R0..R15 by sampling ALUBus.
// Latency: the first instruction appears 1 cycle after Start; each dump value appears 1 cycle after its MOV word.
// Backpressure: Hold stalls sequencing and emits NOP; there are no other flow-control signals.
//
// Ports:
//   Clock       rising-edge clock shared with the Decoder
//   Reset       synchronous, active-low
//   Start       begins the program; honoured only in IDLE or DONE
//   Hold        freezes sequencing and emits NOP (ignored in IDLE)
//   ALUBus      Decoder ALU result for the word currently on Instruction
//   Instruction registered 16-bit instruction to the Decoder
//   Busy        high from the first issued word through the last dump word
//   Done        one-cycle pulse after the final dump word
//   DumpValid   DumpIndex/DumpData valid this cycle
//   DumpIndex   register number being reported
//   DumpData    captured register value
module fib_sequencer #(
  parameter logic [3:0] OP_REG   = 4'b0000,
  parameter logic [3:0] OP_MOVI  = 4'b1101,
  parameter logic [3:0] EXT_ADD  = 4'b0101,
  parameter logic [3:0] EXT_MOV  = 4'b1101,
  parameter logic [7:0] SEED0    = 8'h00,
  parameter logic [7:0] SEED1    = 8'h01,
  parameter int         LAST_REG = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Hold,
  input  logic [15:0] ALUBus,
  output logic [15:0] Instruction,
  output logic        Busy,
  output logic        Done,
  output logic        DumpValid,
  output logic [3:0]  DumpIndex,
  output logic [15:0] DumpData
);

  // MOV R0,R0 doubles as the NOP encoding.
  localparam logic [15:0] NOP  = {OP_REG, 4'h0, EXT_MOV, 4'h0};
  localparam logic [3:0]  LAST = 4'(LAST_REG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED0,
    ST_SEED1,
    ST_COPY,
    ST_ACC,
    ST_DUMP,
    ST_DONE
  } state_t;

  state_t     state;
  logic [3:0] i;          // register being computed
  logic [3:0] j;          // register being dumped
  logic       dump_pend;  // the word now on Instruction is a dump MOV
  logic [3:0] pend_idx;   // register number of that dump MOV

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      i           <= 4'd0;
      j           <= 4'd0;
      dump_pend   <= 1'b0;
      pend_idx    <= 4'd0;
      Instruction <= NOP;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      DumpValid   <= 1'b0;
      DumpIndex   <= 4'd0;
      DumpData    <= 16'd0;
    end else begin
      // ALUBus reflects the word presented during this cycle, so a dump MOV
      // issued at the previous edge is captured here, one cycle after it.
      DumpValid <= dump_pend;
      if (dump_pend) begin
        DumpIndex <= pend_idx;
        DumpData  <= ALUBus;
      end
      dump_pend <= 1'b0;
      Done      <= 1'b0;

      case (state)
        ST_IDLE: begin
          Instruction <= NOP;
          Busy        <= 1'b0;
          if (Start) state <= ST_SEED0;
        end

        // DONE is a single pulse cycle; Hold does not stretch it.
        ST_DONE: begin
          Instruction <= NOP;
          Busy        <= 1'b0;
          Done        <= 1'b1;
          state       <= Start ? ST_SEED0 : ST_IDLE;
        end

        default: begin
          Busy <= 1'b1;
          if (Hold) begin
            // Stall: the pending word is reissued once Hold drops.
            Instruction <= NOP;
          end else begin
            case (state)
              ST_SEED0: begin
                Instruction <= {OP_MOVI, 4'h0, SEED0};
                state       <= ST_SEED1;
              end
              ST_SEED1: begin
                Instruction <= {OP_MOVI, 4'h1, SEED1};
                i           <= 4'd2;
                state       <= ST_COPY;
              end
              ST_COPY: begin
                Instruction <= {OP_REG, i, EXT_MOV, i - 4'd1};
                state       <= ST_ACC;
              end
              ST_ACC: begin
                Instruction <= {OP_REG, i, EXT_ADD, i - 4'd2};
                if (i == LAST) begin
                  j     <= 4'd0;
                  state <= ST_DUMP;
                end else begin
                  i     <= i + 4'd1;
                  state <= ST_COPY;
                end
              end
              ST_DUMP: begin
                Instruction <= {OP_REG, j, EXT_MOV, j};
                dump_pend   <= 1'b1;
                pend_idx    <= j;
                if (j == 4'hF) state <= ST_DONE;
                else           j     <= j + 4'd1;
              end
              default: begin
                Instruction <= NOP;
                state       <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Purpose: self-checking bench for fib_sequencer with a behavioural Decoder register file.
// Latency: checks the 1-cycle word latency and the 1-cycle dump capture alignment.
// Backpressure: exercises Hold stalls, both fixed and random.
module tb_fib_sequencer;

  localparam logic [15:0] NOP = 16'h00D0;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  // instance A: default parameters
  logic        ra, sa, ha;
  logic [15:0] alu_a, ins_a, ddat_a;
  logic        busy_a, done_a, dv_a;
  logic [3:0]  didx_a;

  // instance B: LAST_REG=4, seeds 2 and 1
  logic        rb, sb, hb;
  logic [15:0] alu_b, ins_b, ddat_b;
  logic        busy_b, done_b, dv_b;
  logic [3:0]  didx_b;

  fib_sequencer dut_a (
    .Clock(Clock), .Reset(ra), .Start(sa), .Hold(ha), .ALUBus(alu_a),
    .Instruction(ins_a), .Busy(busy_a), .Done(done_a), .DumpValid(dv_a),
    .DumpIndex(didx_a), .DumpData(ddat_a)
  );

  fib_sequencer #(.SEED0(8'h02), .SEED1(8'h01), .LAST_REG(4)) dut_b (
    .Clock(Clock), .Reset(rb), .Start(sb), .Hold(hb), .ALUBus(alu_b),
    .Instruction(ins_b), .Busy(busy_b), .Done(done_b), .DumpValid(dv_b),
    .DumpIndex(didx_b), .DumpData(ddat_b)
  );

  // Behavioural Decoder: {write enable, ALU result} for one instruction word.
  function automatic logic [16:0] exec(input logic [15:0] ins, input logic [15:0] rf [16]);
    logic [16:0] r;
    r = '0;
    if (ins[15:12] == 4'hD)
      r = {1'b1, 8'h00, ins[7:0]};
    else if (ins[15:12] == 4'h0 && ins[7:4] == 4'hD)
      r = {1'b1, rf[ins[3:0]]};
    else if (ins[15:12] == 4'h0 && ins[7:4] == 4'h5)
      r = {1'b1, rf[ins[11:8]] + rf[ins[3:0]]};
    return r;
  endfunction

  logic [15:0] rf_a [16];
  logic [15:0] rf_b [16];
  logic [16:0] res_a, res_b;

  always_comb begin
    res_a = exec(ins_a, rf_a);
    res_b = exec(ins_b, rf_b);
  end
  assign alu_a = res_a[15:0];
  assign alu_b = res_b[15:0];

  always @(posedge Clock) begin
    if (!ra) begin
      for (int k = 0; k < 16; k++) rf_a[k] <= '0;
    end else if (res_a[16]) begin
      rf_a[ins_a[11:8]] <= res_a[15:0];
    end
    if (!rb) begin
      for (int k = 0; k < 16; k++) rf_b[k] <= '0;
    end else if (res_b[16]) begin
      rf_b[ins_b[11:8]] <= res_b[15:0];
    end
  end

  // Reference: expected dump values and expected program words.
  logic [15:0] fa [16];
  logic [15:0] fb [16];
  logic [15:0] prog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs one full program on instance A and checks word trace, dump stream,
  // Busy length and the Done pulse. mode: 0 no hold, 1 hold on COPY i=7,
  // 2 random hold/start. restart_next raises Start in the DONE cycle.
  task automatic run_prog(input string tag, input int mode, input bit do_start, input bit restart_next);
    int pc, nd, nbusy, nhold;
    bit hq, fin;
    pc = 0; nd = 0; nbusy = 0; nhold = 0; fin = 0;
    if (do_start) begin
      sa = 1'b1;
      tick();
      sa = 1'b0;
    end
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      hq = 1'b0;
      if (cyc <= 30) begin
        if (mode == 1) hq = (cyc >= 13 && cyc <= 15);
        else if (mode == 2) hq = ($urandom_range(0, 3) == 0);
      end
      ha = hq;
      if (hq) nhold++;
      sa = (mode == 2 && cyc <= 40) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (restart_next && pc == 46) sa = 1'b1;
      tick();
      ha = 1'b0;
      if (cyc == 1) check($sformatf("%s busy_at_start", tag), busy_a, 1);
      if (busy_a) begin
        nbusy++;
        if (hq) check($sformatf("%s hold_nop", tag), ins_a, NOP);
        else if (pc < 46) begin
          check($sformatf("%s word%0d", tag, pc), ins_a, prog[pc]);
          pc++;
        end else check($sformatf("%s overrun", tag), pc, 45);
      end
      if (dv_a) begin
        check($sformatf("%s dump_idx%0d", tag, nd), didx_a, nd & 15);
        if (nd < 16) check($sformatf("%s dump_dat%0d", tag, nd), ddat_a, fa[nd]);
        nd++;
      end
      if (done_a) fin = 1'b1;
    end
    sa = 1'b0;
    check($sformatf("%s done_seen", tag), fin, 1);
    check($sformatf("%s dump_count", tag), nd, 16);
    check($sformatf("%s busy_cycles", tag), nbusy, 46 + nhold);
    if (!restart_next) begin
      tick();
      check($sformatf("%s idle_after_done", tag), {busy_a, done_a, dv_a}, 0);
    end
  endtask

  typedef struct packed {
    logic        r, s, h;
    logic [15:0] ins;
    logic        busy, done, dv;
  } vec_t;

  vec_t vt [12];

  initial begin
    int nb, nd;
    bit fin;
    ra = 0; sa = 0; ha = 0;
    rb = 0; sb = 0; hb = 0;

    fa[0] = 16'h0000; fa[1] = 16'h0001;
    for (int k = 2; k < 16; k++) fa[k] = fa[k-1] + fa[k-2];
    for (int k = 0; k < 16; k++) fb[k] = 16'h0000;
    fb[0] = 16'h0002; fb[1] = 16'h0001;
    for (int k = 2; k <= 4; k++) fb[k] = fb[k-1] + fb[k-2];

    prog.push_back({4'hD, 4'h0, 8'h00});
    prog.push_back({4'hD, 4'h1, 8'h01});
    for (int k = 2; k <= 15; k++) begin
      prog.push_back({4'h0, 4'(k), 4'hD, 4'(k - 1)});
      prog.push_back({4'h0, 4'(k), 4'h5, 4'(k - 2)});
    end
    for (int k = 0; k < 16; k++) prog.push_back({4'h0, 4'(k), 4'hD, 4'(k)});

    // reset state
    tick();
    check("rst_instr", ins_a, NOP);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_dv", dv_a, 0);
    check("rst_didx", didx_a, 0);
    check("rst_ddat", ddat_a, 0);

    // cycle-by-cycle vectors: reset priority, Start+Hold in IDLE, ignored
    // Start while busy, a hold stall, then a mid-stream reset abort
    vt[0]  = '{1'b0, 1'b0, 1'b0, 16'h00D0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 16'h00D0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 16'h00D0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 16'h00D0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 16'hD000, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 16'hD101, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h02D1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 16'h0250, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 16'h00D0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 16'h03D2, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 16'h0351, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 16'h00D0, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 12; v++) begin
      ra = vt[v].r; sa = vt[v].s; ha = vt[v].h;
      tick();
      check($sformatf("vec%0d {instr,busy,done,dv}", v),
            {ins_a, busy_a, done_a, dv_a},
            {vt[v].ins, vt[v].busy, vt[v].done, vt[v].dv});
    end
    ra = 1; sa = 0; ha = 0;

    run_prog("basic", 0, 1'b1, 1'b0);
    run_prog("hold_i7", 1, 1'b1, 1'b0);

    // reset while dumping R5
    sa = 1; tick(); sa = 0;
    repeat (36) tick();
    check("dump_j5_word", ins_a, 16'h05D5);
    check("dump_j4_valid", {dv_a, didx_a}, {1'b1, 4'd4});
    ra = 0; tick();
    check("abort {instr,busy,dv}", {ins_a, busy_a, dv_a}, {NOP, 1'b0, 1'b0});
    ra = 1;
    run_prog("after_abort", 0, 1'b1, 1'b0);

    // Start held in DONE restarts with no IDLE cycle
    run_prog("restart_first", 0, 1'b1, 1'b1);
    run_prog("restart_second", 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) run_prog($sformatf("rand%0d", r), 2, 1'b1, 1'b0);

    // instance B: short program, R5..R15 stay at their reset value
    rb = 0; tick();
    rb = 1; sb = 1; tick(); sb = 0;
    nb = 0; nd = 0; fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      tick();
      if (busy_b) nb++;
      if (dv_b) begin
        check($sformatf("b dump_idx%0d", nd), didx_b, nd & 15);
        if (nd < 16) check($sformatf("b dump_dat%0d", nd), ddat_b, fb[nd]);
        nd++;
      end
      if (done_b) fin = 1;
    end
    check("b done_seen", fin, 1);
    check("b dump_count", nd, 16);
    check("b busy_cycles", nb, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
